// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP types, rounding modes and fadd arbiter states
package fpu_pkg;

  typedef logic [31:0] fp32_t;
  typedef logic [2:0]  rm_t;

  localparam rm_t RM_RNE = 3'd0;
  localparam rm_t RM_RTZ = 3'd1;
  localparam rm_t RM_RDN = 3'd2;
  localparam rm_t RM_RUP = 3'd3;
  localparam rm_t RM_RMM = 3'd4;

  localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fadd_arb_state_t;

endpackage

// File: rtl/fadd.sv
// rtl/fadd.sv - combinational IEEE-754 single-precision adder, five rounding modes
module fadd
  import fpu_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  input  rm_t   rm,
  output fp32_t y
);
  logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, sgn;
  logic        inc, lsb, g, rs, hid, ovf_max;
  fp32_t       x, z;
  logic [9:0]  ex, ez, d, sh, e_n, e_r;
  logic [23:0] mx, mz;
  logic [53:0] wide;
  logic [26:0] mz_al, n;
  logic [27:0] s;
  logic [4:0]  lz;
  logic [24:0] m;
  logic [22:0] mant;

  always_comb begin
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && !(|a[22:0]);
    b_inf = (&b[30:23]) && !(|b[22:0]);
    swap  = b[30:0] > a[30:0];
    x     = swap ? b : a;
    z     = swap ? a : b;
    ex    = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ez    = (z[30:23] == 8'd0) ? 10'd1 : {2'b00, z[30:23]};
    mx    = {|x[30:23], x[22:0]};
    mz    = {|z[30:23], z[22:0]};
    d     = ex - ez;
    // Three extra low bits carry guard/round/sticky through alignment.
    wide  = {mz, 30'd0} >> ((d > 10'd27) ? 10'd27 : d);
    mz_al = {wide[53:28], wide[27] | (|wide[26:0])};
    eff_sub = x[31] ^ z[31];
    sgn     = x[31];
    s = eff_sub ? ({1'b0, mx, 3'b000} - {1'b0, mz_al})
                : ({1'b0, mx, 3'b000} + {1'b0, mz_al});

    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end

    sh = 10'd0;
    if (s[27]) begin
      n   = {s[27:2], s[1] | s[0]};
      e_n = ex + 10'd1;
    end else begin
      // Stop normalising at exponent 1 so tiny results land as subnormals.
      sh  = ({5'd0, lz} < (ex - 10'd1)) ? {5'd0, lz} : (ex - 10'd1);
      n   = s[26:0] << sh;
      e_n = ex - sh;
    end

    lsb = n[3];
    g   = n[2];
    rs  = n[1] | n[0];
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sgn & (g | rs);
      RM_RUP:  inc = ~sgn & (g | rs);
      RM_RMM:  inc = g;
      default: inc = g & (rs | lsb);
    endcase

    m       = {1'b0, n[26:3]} + {24'd0, inc};
    e_r     = m[24] ? (e_n + 10'd1) : e_n;
    mant    = m[24] ? 23'd0 : m[22:0];
    hid     = m[24] | m[23];
    ovf_max = (rm == RM_RTZ) || ((rm == RM_RDN) && !sgn) || ((rm == RM_RUP) && sgn);

    if (e_r >= 10'd255)
      y = ovf_max ? {sgn, 8'hFE, 23'h7FFFFF} : {sgn, 8'hFF, 23'd0};
    else
      y = {sgn, hid ? e_r[7:0] : 8'h00, mant};

    if (s == 28'd0) y = {eff_sub ? (rm == RM_RDN) : sgn, 31'd0};

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) y = FP32_QNAN;
    else if (a_inf) y = a;
    else if (b_inf) y = b;
  end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - round-robin pick of the first request at or after ptr
module fpu_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);

  logic         found;
  logic [W-1:0] j;

  // Scanning from the far end lets the candidate nearest ptr win last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
    gnt = '0;
    if (en && found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fadd_arbiter.sv
// rtl/fadd_arbiter.sv - shares one fadd among NREQ requesters, one op in flight
module fadd_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  input  logic [NREQ-1:0][2:0]  req_rm,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [31:0]           resp_data,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);

  fadd_arb_state_t state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d, grant_q, grant_d, gnt_idx;
  fp32_t           a_q, a_d, b_q, b_d, res_q, res_d, fadd_y;
  rm_t             rm_q, rm_d;
  logic [NREQ-1:0] gnt;
  logic            arb_en;

  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign arb_en = (state_q == IDLE) && rst_n;

  fpu_rr_arbiter #(.N(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  fadd u_fadd (
    .a  (a_q),
    .b  (b_q),
    .rm (rm_q),
    .y  (fadd_y)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    a_d        = a_q;
    b_d        = b_q;
    rm_d       = rm_q;
    res_d      = res_q;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          a_d      = req_a[gnt_idx];
          b_d      = req_b[gnt_idx];
          rm_d     = req_rm[gnt_idx];
          grant_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_d   = fadd_y;
        state_d = RESP;
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rm_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rm_q     <= rm_d;
      res_q    <= res_d;
    end
  end

  assign req_ready = gnt;
  assign resp_data = res_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fadd_arbiter.sv
// tb/tb_fadd_arbiter.sv - directed self-checking bench for fadd_arbiter
module tb_fadd_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [3:0][31:0] req_a, req_b;
  logic [3:0][2:0]  req_rm;
  logic [31:0]      resp_data;
  logic             busy;
  logic [31:0]      ref_a, ref_b, ref_y;
  logic [2:0]       ref_rm;
  logic [31:0]      rr_exp [4];
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  fadd_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
  );

  fadd u_ref (.a(ref_a), .b(ref_b), .rm(ref_rm), .y(ref_y));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [31:0] want, input string tag);
    req_a[r]   = a;
    req_b[r]   = b;
    req_rm[r]  = rm;
    req_valid  = 4'(1 << r);
    resp_ready = 4'(1 << r);
    #1;
    chk({tag, "_ready"}, {28'd0, req_ready}, 32'(1 << r));
    tick;
    req_valid = 4'b0000;
    chk({tag, "_busy_exec"}, {31'd0, busy}, 32'd1);
    chk({tag, "_no_resp_exec"}, {28'd0, resp_valid}, 32'd0);
    tick;
    chk({tag, "_resp_valid"}, {28'd0, resp_valid}, 32'(1 << r));
    chk({tag, "_resp_data"}, resp_data, want);
    chk({tag, "_busy_resp"}, {31'd0, busy}, 32'd1);
    tick;
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 4'b0000;
    req_a = '0;
    req_b = '0;
    req_rm = '0;
    ref_a = '0;
    ref_b = '0;
    ref_rm = '0;
    rr_exp[0] = 32'h3F80_0000;
    rr_exp[1] = 32'h4000_0000;
    rr_exp[2] = 32'h4040_0000;
    rr_exp[3] = 32'h4080_0000;
    #22;
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    req_valid = 4'b0000;
    rst_n = 1'b1;

    // 1.0 + 2.0 from requester 2, accepted on the first edge after release
    do_op(2, 32'h3F80_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, "single");

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_a[k]  = 32'h3F80_0000;
      req_rm[k] = 3'd0;
    end
    req_b[0] = 32'h0000_0000;
    req_b[1] = 32'h3F80_0000;
    req_b[2] = 32'h4000_0000;
    req_b[3] = 32'h4040_0000;
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), {28'd0, req_ready}, 32'(1 << (k % 4)));
      tick;
      tick;
      chk($sformatf("rr_resp_valid%0d", k), {28'd0, resp_valid}, 32'(1 << (k % 4)));
      chk($sformatf("rr_resp_data%0d", k), resp_data, rr_exp[k % 4]);
      tick;
    end

    // Requester 1 stalls its response; pointer now sits at 1
    req_valid  = 4'b0010;
    resp_ready = 4'b0001;
    req_b[1]   = 32'h3F80_0000;
    #1;
    chk("bp_grant", {28'd0, req_ready}, 32'h2);
    tick;
    req_valid = 4'b1111;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), {28'd0, resp_valid}, 32'h2);
      chk($sformatf("bp_data%0d", k), resp_data, 32'h4000_0000);
      chk($sformatf("bp_no_ready%0d", k), {28'd0, req_ready}, 32'd0);
      tick;
    end
    resp_ready = 4'b0011;
    tick;
    chk("bp_idle", {31'd0, busy}, 32'd0);
    chk("bp_next_ptr", {28'd0, req_ready}, 32'h4);
    req_valid = 4'b0000;
    tick;

    do_op(3, 32'h3F80_0000, 32'h4040_0000, 3'd0, 32'h4080_0000, "fair3");
    req_valid  = 4'b1001;
    resp_ready = 4'b1111;
    #1;
    chk("fair_first0", {28'd0, req_ready}, 32'h1);
    tick;
    tick;
    chk("fair_resp0", {28'd0, resp_valid}, 32'h1);
    tick;
    chk("fair_then3", {28'd0, req_ready}, 32'h8);
    req_valid = 4'b0000;
    #1;

    req_valid = 4'b0010;
    tick;
    req_valid = 4'b0000;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("mid_rst_resp_data", resp_data, 32'd0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("mid_no_resp", {28'd0, resp_valid}, 32'd0);
    chk("mid_idle", {31'd0, busy}, 32'd0);
    req_valid = 4'b1001;
    #1;
    chk("mid_ptr_reset", {28'd0, req_ready}, 32'h1);
    req_valid = 4'b0000;
    #1;

    ref_a = 32'h7F80_0000; ref_b = 32'hFF80_0000; ref_rm = 3'd0;
    do_op(0, ref_a, ref_b, ref_rm, 32'h7FC0_0000, "pt_inf");
    chk("pt_inf_ref", resp_data, ref_y);
    ref_a = 32'h0000_0000; ref_b = 32'h0000_0001; ref_rm = 3'd0;
    do_op(0, ref_a, ref_b, ref_rm, 32'h0000_0001, "pt_sub");
    chk("pt_sub_ref", resp_data, ref_y);
    ref_a = 32'h3F80_0000; ref_b = 32'hBF80_0000; ref_rm = 3'd2;
    do_op(0, ref_a, ref_b, ref_rm, 32'h8000_0000, "pt_rdn");
    chk("pt_rdn_ref", resp_data, ref_y);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
